jk_reg_bank: RTL



---
 rtl/jk_pkg.sv | 18 +
 rtl/jk_cell.sv | 35 +++
 rtl/jk_reg_bank.sv | 129 ++++++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for the JK register bank.
//   - mode_t and the MODE_* constants select how each cell's J/K is driven.
//   - jk_next() is the characteristic equation of one JK cell.
package jk_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_JK  = 2'b00;
    localparam mode_t MODE_UP  = 2'b01;
    localparam mode_t MODE_DN  = 2'b10;
    localparam mode_t MODE_SHL = 2'b11;

    // 00 hold, 10 set, 01 reset, 11 toggle
    function automatic logic jk_next(input logic j, input logic k, input logic q);
        return (j & ~q) | (~k & q);
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK flip-flop with synchronous reset, parallel load and enable.
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset, q <= rst_val
//   rst_val value taken on reset
//   ld      load strobe, q <= ld_val (below rst in priority)
//   ld_val  value taken on load
//   en      advance enable for the JK update (below ld in priority)
//   j, k    JK inputs
//   q       cell state
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic ld,
    input  logic ld_val,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= rst_val;
        end else if (ld) begin
            q <= ld_val;
        end else if (en) begin
            q <= jk_next(j, k, q);
        end
    end

endmodule

// File: rtl/jk_reg_bank.sv
// WIDTH-bit bank of JK cells with mode-selected J/K drive.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (q <= RST_VAL, chg <= 0)
//   en        advance enable for JK/count/shift
//   mode      00 per-bit JK, 01 count up, 10 count down, 11 shift left
//   load      parallel load strobe (beats en)
//   load_val  value written on load
//   j, k      per-bit JK inputs, used in mode 00 only
//   ser_in    serial input into bit 0, used in mode 11 only
//   q         register state
//   q_n       ~q
//   tc        terminal count: all-ones when counting up, all-zeros when counting down
//   chg       registered: q changed on the previous edge
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             tc,
    output logic             chg
);

    logic [WIDTH-1:0] j_eff;
    logic [WIDTH-1:0] k_eff;
    logic [WIDTH-1:0] up_t;    // bit i toggles when all lower bits are 1
    logic [WIDTH-1:0] dn_t;    // bit i toggles when all lower bits are 0
    logic [WIDTH-1:0] shl_in;  // value arriving at each bit on a shift
    logic [WIDTH-1:0] q_next;
    logic             chg_q;

    // Ripple the toggle conditions through local accumulators so the chains
    // do not form a self-referencing vector.
    always_comb begin
        logic up_acc;
        logic dn_acc;
        up_acc = 1'b1;
        dn_acc = 1'b1;
        up_t   = '0;
        dn_t   = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            up_t[i] = up_acc;
            dn_t[i] = dn_acc;
            up_acc  = up_acc & q[i];
            dn_acc  = dn_acc & ~q[i];
        end
    end

    assign shl_in = {q[WIDTH-2:0], ser_in};

    // Unused inputs never reach the cells, so they cannot inject X.
    always_comb begin
        j_eff = '0;
        k_eff = '0;
        unique case (mode)
            MODE_JK: begin
                j_eff = j;
                k_eff = k;
            end
            MODE_UP: begin
                j_eff = up_t;
                k_eff = up_t;
            end
            MODE_DN: begin
                j_eff = dn_t;
                k_eff = dn_t;
            end
            MODE_SHL: begin
                j_eff = shl_in;
                k_eff = ~shl_in;
            end
            default: begin
                j_eff = '0;
                k_eff = '0;
            end
        endcase
    end

    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_cell
        jk_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .rst_val (RST_VAL[gi]),
            .ld      (load),
            .ld_val  (load_val[gi]),
            .en      (en),
            .j       (j_eff[gi]),
            .k       (k_eff[gi]),
            .q       (q[gi])
        );
    end

    // Next state as the cells will see it (below reset), used only to flag a change.
    always_comb begin
        q_next = q;
        if (load) begin
            q_next = load_val;
        end else if (en) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                q_next[i] = jk_next(j_eff[i], k_eff[i], q[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chg_q <= 1'b0;
        end else begin
            chg_q <= (q_next != q);
        end
    end

    assign chg = chg_q;
    assign q_n = ~q;
    assign tc  = ((mode == MODE_UP) && (&q)) || ((mode == MODE_DN) && ~(|q));

endmodule
